alu_mul_seq: RTL and testbench
==============================

Name: alu_mul_seq

Overview:
- Multi-cycle sequencer that computes a 16-bit multiply (low word of product) by driving a shared, external ALU16 (Hack-style zx/nx/zy/ny/f/no controls) through a shift-add microsequence.
- Sits beside the CPU datapath. It requests the ALU via a req/gnt pair and stalls whenever the grant is withheld.
- Result is the low 16 bits. This is identical for signed (two's complement) and unsigned operands.

Parameters:
- WIDTH, 16, number of multiplier bits iterated; must equal the ALU data width.
- EARLY_EXIT, 0, if 1, terminate as soon as the remaining multiplier bits are all zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a multiply; sampled only when idle.
- a  in  WIDTH  multiplicand, captured on start acceptance.
- b  in  WIDTH  multiplier, captured on start acceptance.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when product is updated.
- product  out  WIDTH  last completed result, held until the next completion.
- alu_req  out  1  ALU ownership request; equals busy.
- alu_gnt  in  1  ALU granted this cycle; when low, the sequencer holds all state.
- alu_x, alu_y  out  WIDTH  ALU operands.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits.
- alu_out  in  WIDTH  combinational ALU result, sampled at the clock edge.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, alu_req = 0.
  - product, internal acc/m/mplr/cnt = 0.
  - All alu_* outputs = 0.
- Reset mid-operation aborts immediately with no done pulse.
- States: IDLE, CLR, ADD, DBL.
- IDLE:
  - alu_* outputs driven 0.
  - On an edge with start=1: m<=a, mplr<=b, cnt<=0, go to CLR. busy rises after that edge.
- Grant stall: in CLR/ADD/DBL, an edge with alu_gnt=0 changes nothing (state, acc, m, mplr, cnt held). ALU outputs stay driven.
- CLR:
  - Controls zx=1 nx=0 zy=1 ny=0 f=1 no=0 (ALU computes 0).
  - acc<=alu_out; go to ADD.
- ADD:
  - alu_x=acc, alu_y=m, controls 0,0,0,0,1,0 (x+y).
  - acc<=alu_out only if mplr[0]=1. Go to DBL.
- DBL:
  - alu_x=m, alu_y=m, controls x+y.
  - m<=alu_out, mplr<=mplr>>1 (logical), cnt<=cnt+1.
  - Finish if cnt+1==WIDTH, or if EARLY_EXIT=1 and mplr>>1==0. Otherwise go to ADD.
- Finish edge:
  - product<=acc. acc already holds the final value, since the last ADD precedes DBL.
  - done<=1 for exactly one cycle; busy<=0; state IDLE.
- Latency (gnt always 1, EARLY_EXIT=0):
  - start accepted at edge E0; CLR at E1; ADD/DBL at E2..E33.
  - done high and product valid in the cycle after E33.
  - Each stalled edge adds one cycle.
- Early exit: a run with k executed bit iterations finishes at edge E(1+2k). b=0 gives k=1 (done after E3).
- Arithmetic:
  - All ALU additions wrap modulo 2^WIDTH.
  - m doubling past the MSB discards the carry; overflow is not flagged.
- start while busy: ignored, with no effect on captured operands.
- start during the done cycle: accepted, since state is already IDLE. product holds until the new finish.
- alu_req deasserts in the same cycle done pulses.

Test Plan:
- a=7, b=6, gnt=1 -> done exactly 33 edges after start acceptance; product=42 (0x002A); busy low with done.
- a=0xFFFD (-3), b=5 -> product=0xFFF1 (-15); a=0x0100, b=0x0100 -> product=0x0000 (wrap).
- a=7, b=6, alu_gnt low for 10 edges starting at E8 -> done after E43; product=42; alu_* operands stable during the stall.
- Mid-run start with a=1, b=1 at E5, followed by b2b start in the done cycle -> first product=42 unaffected; second op accepted in the done cycle.
- rst_n pulsed low at E12 mid-run -> busy, done, product=0 immediately; no done pulse; a fresh start afterwards completes normally.
- EARLY_EXIT=1, a=9, b=3 -> done after E5, product=27; b=0 -> done after E3, product=0.

Source files
------------

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 16-bit multiply (low word) computed by sequencing a shared,
// external Hack-style ALU through a shift-add loop. The ALU is owned only
// while busy. Every step waits for alu_gnt, so a withheld grant freezes the
// whole sequencer. The low product word is the same for signed and unsigned
// operands.
module alu_mul_seq #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_ADD  = 2'd2,
        S_DBL  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_mplr;
    logic [WIDTH-1:0] r_product;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             w_last_iter;
    logic             w_finish;

    // The last iteration is either the WIDTH-th doubling, or (with early exit)
    // the first doubling after which no multiplier bits remain set.
    assign w_last_iter = (r_cnt == LAST_CNT) ||
                         (EARLY_EXIT && ((r_mplr >> 1) == '0));
    assign w_finish    = (r_state == S_DBL) && alu_gnt && w_last_iter;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: IDLE waits for start, every other state advances only on grant
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start)   w_next = S_CLR;
            S_CLR:  if (alu_gnt) w_next = S_ADD;
            S_ADD:  if (alu_gnt) w_next = S_DBL;
            S_DBL:  if (alu_gnt) w_next = w_last_iter ? S_IDLE : S_ADD;
            default:             w_next = S_IDLE;
        endcase
    end

    // Working registers: operand capture, then ALU results written back per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_m    <= '0;
            r_mplr <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m    <= a;
                        r_mplr <= b;
                        r_cnt  <= '0;
                    end
                end
                S_CLR: begin
                    if (alu_gnt) r_acc <= alu_out;
                end
                S_ADD: begin
                    if (alu_gnt && r_mplr[0]) r_acc <= alu_out;
                end
                S_DBL: begin
                    if (alu_gnt) begin
                        r_m    <= alu_out;
                        r_mplr <= r_mplr >> 1;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result and done pulse: the final ADD already settled acc before the last DBL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) r_product <= r_acc;
        end
    end

    // Outputs: ALU operands/controls per state; all zero while idle
    always_comb begin
        alu_x  = '0;
        alu_y  = '0;
        alu_zx = 1'b0;
        alu_nx = 1'b0;
        alu_zy = 1'b0;
        alu_ny = 1'b0;
        alu_f  = 1'b0;
        alu_no = 1'b0;
        case (r_state)
            S_CLR: begin
                alu_zx = 1'b1;
                alu_zy = 1'b1;
                alu_f  = 1'b1;
            end
            S_ADD: begin
                alu_x = r_acc;
                alu_y = r_m;
                alu_f = 1'b1;
            end
            S_DBL: begin
                alu_x = r_m;
                alu_y = r_m;
                alu_f = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign alu_req = busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: two instances (EARLY_EXIT 0 and 1), each with its own
// Hack ALU model, driven by a vector table, random operands and hand sequences.
module tb_alu_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start0, start1;
    logic [15:0] a, b;
    logic        gnt;

    logic        busy0, done0, req0, zx0, nx0, zy0, ny0, f0, no0;
    logic [15:0] product0, x0, y0, aluo0;
    logic        busy1, done1, req1, zx1, nx1, zy1, ny1, f1, no1;
    logic [15:0] product1, x1, y1, aluo1;

    int total;
    int bad;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] prod;
        int          ee_edges;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic zx, input logic nx,
                                             input logic zy, input logic ny,
                                             input logic f,  input logic no);
        logic [15:0] xx, yy, o;
        xx = zx ? 16'h0000 : x;
        if (nx) xx = ~xx;
        yy = zy ? 16'h0000 : y;
        if (ny) yy = ~yy;
        o = f ? (xx + yy) : (xx & yy);
        if (no) o = ~o;
        return o;
    endfunction

    function automatic logic [15:0] mul_model(input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = {16'h0000, x} * {16'h0000, y};
        return p[15:0];
    endfunction

    // Iterations run until no set multiplier bit remains (at least one).
    function automatic int early_edges(input logic [15:0] y);
        int k;
        k = 1;
        for (int i = 0; i < 16; i++) if (y[i]) k = i + 1;
        return 1 + 2 * k;
    endfunction

    assign aluo0 = hack_alu(x0, y0, zx0, nx0, zy0, ny0, f0, no0);
    assign aluo1 = hack_alu(x1, y1, zx1, nx1, zy1, ny1, f1, no1);

    alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b),
        .busy(busy0), .done(done0), .product(product0),
        .alu_req(req0), .alu_gnt(gnt), .alu_x(x0), .alu_y(y0),
        .alu_zx(zx0), .alu_nx(nx0), .alu_zy(zy0), .alu_ny(ny0),
        .alu_f(f0), .alu_no(no0), .alu_out(aluo0)
    );

    alu_mul_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b),
        .busy(busy1), .done(done1), .product(product1),
        .alu_req(req1), .alu_gnt(gnt), .alu_x(x1), .alu_y(y1),
        .alu_zx(zx1), .alu_nx(nx1), .alu_zy(zy1), .alu_ny(ny1),
        .alu_f(f1), .alu_no(no1), .alu_out(aluo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Start both instances together; called at posedge+1, returns at posedge+1.
    task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] eprod, input int eedges, input string tag);
        int n0, n1;
        a = va; b = vb; start0 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        chk({tag, "_busy"}, {busy0, req0, busy1, req1}, 4'b1111);
        n0 = 0; n1 = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (done0 && n0 == 0) begin
                n0 = e;
                chk({tag, "_prod0"}, product0, eprod);
                chk({tag, "_idle0"}, {busy0, req0}, 2'b00);
            end
            if (done1 && n1 == 0) begin
                n1 = e;
                chk({tag, "_prod1"}, product1, eprod);
                chk({tag, "_idle1"}, {busy1, req1}, 2'b00);
            end
            if (n0 != 0 && n1 != 0) break;
        end
        chk({tag, "_lat0"}, n0, 33);
        chk({tag, "_lat1"}, n1, eedges);
    endtask

    initial begin
        logic [15:0] ra, rb, sx, sy;
        logic [5:0]  sc;
        logic        stable, seen;
        int          n;

        total = 0;
        bad   = 0;

        vecs[0] = '{16'd7,    16'd6,    16'd42,   7};
        vecs[1] = '{16'hFFFD, 16'd5,    16'hFFF1, 7};
        vecs[2] = '{16'h0100, 16'h0100, 16'h0000, 19};
        vecs[3] = '{16'd9,    16'd3,    16'd27,   5};
        vecs[4] = '{16'h1234, 16'd0,    16'h0000, 3};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 16'h0001, 33};
        vecs[6] = '{16'h0003, 16'h8000, 16'h8000, 33};
        vecs[7] = '{16'd0,    16'd1,    16'h0000, 3};

        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
        a = '0; b = '0; gnt = 1'b1;
        #3;
        chk("rst_status0", {busy0, done0, req0}, 3'b000);
        chk("rst_product0", product0, 16'h0000);
        chk("rst_alu0", {x0, y0, zx0, nx0, zy0, ny0, f0, no0}, 32'h0);
        chk("rst_status1", {busy1, done1, req1, product1}, 19'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].ee_edges, $sformatf("vec%0d", i));

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom & 32'h00FF);
            run_op(ra, rb, mul_model(ra, rb), early_edges(rb), $sformatf("rnd%0d", i));
        end

        // Grant withheld for edges E8..E17
        a = 16'd7; b = 16'd6; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        n = 0; stable = 1'b1; sx = '0; sy = '0; sc = '0;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (e >= 8 && e <= 17)
                if (x0 !== sx || y0 !== sy || {zx0, nx0, zy0, ny0, f0, no0} !== sc) stable = 1'b0;
            if (e == 7) begin
                gnt = 1'b0;
                sx = x0; sy = y0; sc = {zx0, nx0, zy0, ny0, f0, no0};
            end
            if (e == 17) gnt = 1'b1;
            if (done0) begin n = e; break; end
        end
        gnt = 1'b1;
        chk("stall_lat", n, 43);
        chk("stall_prod", product0, 16'd42);
        chk("stall_stable", stable, 1'b1);

        // start while busy ignored, then back-to-back start in the done cycle
        a = 16'd7; b = 16'd6; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        n = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (e == 4) begin a = 16'd1; b = 16'd1; start0 = 1'b1; end
            if (e == 5) start0 = 1'b0;
            if (done0) begin n = e; break; end
        end
        chk("midstart_lat", n, 33);
        chk("midstart_prod", product0, 16'd42);
        a = 16'd3; b = 16'd5; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("b2b_accept", busy0, 1'b1);
        chk("b2b_done_pulse", done0, 1'b0);
        chk("b2b_prod_hold", product0, 16'd42);
        n = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); #1;
            if (done0) begin n = e; break; end
        end
        chk("b2b_lat", n, 33);
        chk("b2b_prod", product0, 16'd15);

        // Asynchronous reset mid-run
        a = 16'd7; b = 16'd6; start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_status", {busy0, done0, req0}, 3'b000);
        chk("midrst_product", product0, 16'h0000);
        chk("midrst_alu", {x0, y0, zx0, nx0, zy0, ny0, f0, no0}, 32'h0);
        #2 rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done0 || busy0) seen = 1'b1;
        end
        chk("midrst_quiet", seen, 1'b0);
        run_op(16'd12, 16'd11, 16'd132, 9, "postrst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
